// File: rtl/ahb_tilelinkul_same_size_bridge.sv
// ahb_tilelinkul_same_size_bridge: AHB subordinate to TL-UL manager bridge, equal data widths, one transaction outstanding
package ahb_tilelinkul_same_size_bridge_pkg;
    localparam int AHB_AW  = 32;
    localparam int AHB_DW  = 32;
    localparam int TL_AW   = AHB_AW;
    localparam int TL_DW   = AHB_DW;
    localparam int TL_DBW  = TL_DW / 8;
    localparam int TL_SZW  = 2;
    localparam int TL_SRCW = 8;
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    typedef struct packed {
        logic               a_valid;
        logic [2:0]         a_opcode;
        logic [2:0]         a_param;
        logic [TL_SZW-1:0]  a_size;
        logic [TL_SRCW-1:0] a_source;
        logic [TL_AW-1:0]   a_address;
        logic [TL_DBW-1:0]  a_mask;
        logic [TL_DW-1:0]   a_data;
        logic               d_ready;
    } tl_m2s_t;
    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [TL_SZW-1:0] d_size;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_s2m_t;
endpackage

module ahb_tilelinkul_same_size_bridge
    import ahb_tilelinkul_same_size_bridge_pkg::*;
#(
    parameter logic [TL_SRCW-1:0] SourceId = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                h_sel_i,
    input  logic [AHB_AW-1:0]   h_addr_i,
    input  logic [1:0]          h_trans_i,
    input  logic                h_write_i,
    input  logic [2:0]          h_size_i,
    input  logic [AHB_DW-1:0]   h_wdata_i,
    input  logic [AHB_DW/8-1:0] h_wstrb_i,
    input  logic                h_ready_i,
    output logic                h_readyout_o,
    output logic                h_resp_o,
    output logic [AHB_DW-1:0]   h_rdata_o,
    output tl_m2s_t             tl_o,
    input  tl_s2m_t             tl_i
);
    localparam int OffW = $clog2(TL_DBW);

    typedef enum logic [2:0] {IDLE, AREQ, DWAIT, OKAY, ERR1, ERR2} state_e;

    state_e              state_q;
    logic [AHB_AW-1:0]   addr_q;
    logic                write_q;
    logic [2:0]          size_q;
    logic                a_valid_q;
    logic                d_ready_q;
    logic                accept;
    logic                legal;
    logic [TL_DBW-1:0]   lane_mask;
    logic [TL_DBW-1:0]   mask;
    logic                unused_d;

    assign accept   = h_sel_i & h_ready_i & h_trans_i[1];
    assign legal    = h_size_i <= 3'(OffW);
    assign mask     = write_q ? lane_mask & h_wstrb_i : lane_mask;
    assign unused_d = ^{tl_i.d_opcode, tl_i.d_size};

    // A byte lane is enabled when it falls in the size-aligned container holding addr_q
    always_comb begin
        for (int i = 0; i < TL_DBW; i++) lane_mask[i] = (OffW'(i) >> size_q) == (addr_q[OffW-1:0] >> size_q);
    end

    // A-channel fields are driven only while a request is pending; write data comes straight from the held data phase
    always_comb begin
        tl_o         = '0;
        tl_o.d_ready = d_ready_q;
        if (a_valid_q) begin
            tl_o.a_valid   = 1'b1;
            tl_o.a_opcode  = !write_q ? Get : &mask ? PutFullData : PutPartialData;
            tl_o.a_size    = size_q[TL_SZW-1:0];
            tl_o.a_source  = SourceId;
            tl_o.a_address = addr_q;
            tl_o.a_mask    = mask;
            tl_o.a_data    = h_wdata_i;
        end
    end

    // Transaction FSM with registered AHB response and TL handshake outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            size_q       <= '0;
            a_valid_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            h_readyout_o <= 1'b1;
            h_resp_o     <= 1'b0;
            h_rdata_o    <= '0;
        end else begin
            case (state_q)
                IDLE, OKAY, ERR2: begin
                    if (accept) begin
                        addr_q       <= h_addr_i;
                        write_q      <= h_write_i;
                        size_q       <= h_size_i;
                        state_q      <= legal ? AREQ : ERR1;
                        a_valid_q    <= legal;
                        h_readyout_o <= 1'b0;
                        h_resp_o     <= !legal;
                    end else begin
                        state_q      <= IDLE;
                        h_readyout_o <= 1'b1;
                        h_resp_o     <= 1'b0;
                    end
                end
                AREQ: begin
                    if (tl_i.a_ready) begin
                        state_q   <= DWAIT;
                        a_valid_q <= 1'b0;
                        d_ready_q <= 1'b1;
                    end
                end
                DWAIT: begin
                    if (tl_i.d_valid) begin
                        d_ready_q    <= 1'b0;
                        h_rdata_o    <= write_q ? h_rdata_o : tl_i.d_data;
                        state_q      <= tl_i.d_error ? ERR1 : OKAY;
                        h_readyout_o <= !tl_i.d_error;
                        h_resp_o     <= tl_i.d_error;
                    end
                end
                ERR1: begin
                    state_q      <= ERR2;
                    h_readyout_o <= 1'b1;
                    h_resp_o     <= 1'b1;
                end
                default: begin
                    state_q      <= IDLE;
                    a_valid_q    <= 1'b0;
                    d_ready_q    <= 1'b0;
                    h_readyout_o <= 1'b1;
                    h_resp_o     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_tilelinkul_same_size_bridge.sv
// tb_ahb_tilelinkul_same_size_bridge: directed self-checking bench for the AHB to TL-UL bridge
module tb_ahb_tilelinkul_same_size_bridge;
    import ahb_tilelinkul_same_size_bridge_pkg::*;

    localparam logic [TL_SRCW-1:0] Src = 8'h5A;
    localparam logic [1:0] IdleT = 2'd0, BusyT = 2'd1, NseqT = 2'd2, SeqT = 2'd3;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                h_sel_i = 1'b0;
    logic [AHB_AW-1:0]   h_addr_i = '0;
    logic [1:0]          h_trans_i = IdleT;
    logic                h_write_i = 1'b0;
    logic [2:0]          h_size_i = '0;
    logic [AHB_DW-1:0]   h_wdata_i = '0;
    logic [AHB_DW/8-1:0] h_wstrb_i = '0;
    logic                h_readyout_o;
    logic                h_resp_o;
    logic [AHB_DW-1:0]   h_rdata_o;
    tl_m2s_t             tl_o;
    tl_s2m_t             tl_i = '0;

    int      n_tests = 0;
    int      n_fail = 0;
    int      waits, nreq, unstable;
    logic    last_wait_resp, fin_resp, any_avalid;
    tl_m2s_t cap;

    always #5 clk_i = ~clk_i;

    ahb_tilelinkul_same_size_bridge #(.SourceId(Src)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .h_sel_i(h_sel_i), .h_addr_i(h_addr_i),
        .h_trans_i(h_trans_i), .h_write_i(h_write_i), .h_size_i(h_size_i),
        .h_wdata_i(h_wdata_i), .h_wstrb_i(h_wstrb_i), .h_ready_i(h_readyout_o),
        .h_readyout_o(h_readyout_o), .h_resp_o(h_resp_o), .h_rdata_o(h_rdata_o),
        .tl_o(tl_o), .tl_i(tl_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic addr_phase(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic [2:0] sz);
        h_sel_i   = 1'b1;
        h_trans_i = tr;
        h_addr_i  = a;
        h_write_i = wr;
        h_size_i  = sz;
    endtask

    // Runs the data phase and acts as TL responder; returns at the cycle where h_readyout_o is high
    task automatic data_phase(input logic [31:0] wd, input logic [3:0] ws, input int stall, input logic derr, input logic [31:0] dd);
        logic    got_a = 1'b0;
        logic    got_d = 1'b0;
        logic    snapped = 1'b0;
        tl_m2s_t snap;
        waits = 0; unstable = 0; any_avalid = 1'b0; last_wait_resp = 1'b0; fin_resp = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk_i); #1;
            if (c == 0) begin
                h_sel_i = 1'b0; h_trans_i = IdleT; h_wdata_i = wd; h_wstrb_i = ws;
            end
            if (h_readyout_o) begin
                fin_resp = h_resp_o;
                tl_i.d_valid = 1'b0;
                tl_i.a_ready = 1'b0;
                return;
            end
            waits++;
            last_wait_resp = h_resp_o;
            tl_i.a_ready = (c >= stall);
            tl_i.d_valid = got_a && !got_d;
            tl_i.d_error = derr;
            tl_i.d_data  = dd;
            #1;
            if (tl_o.a_valid) begin
                any_avalid = 1'b1;
                if (!snapped) begin snap = tl_o; snapped = 1'b1; end
                else if (snap !== tl_o) unstable++;
                if (tl_i.a_ready) begin got_a = 1'b1; nreq++; cap = tl_o; end
            end
            if (tl_o.d_ready && tl_i.d_valid) got_d = 1'b1;
        end
        check("timeout_readyout", 64'(h_readyout_o), 1);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_readyout", 64'(h_readyout_o), 1);
        check("rst_resp", 64'(h_resp_o), 0);
        check("rst_rdata", 64'(h_rdata_o), 0);
        check("rst_tl_o", 64'(|tl_o), 0);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;

        nreq = 0;
        addr_phase(NseqT, 32'h1000, 1'b0, 3'd2);
        data_phase(32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF);
        check("rd_waits", 64'(waits), 2);
        check("rd_resp", 64'(fin_resp), 0);
        check("rd_opcode", 64'(cap.a_opcode), 64'(Get));
        check("rd_mask", 64'(cap.a_mask), 4'hF);
        check("rd_addr", 64'(cap.a_address), 32'h1000);
        check("rd_size", 64'(cap.a_size), 2);
        check("rd_source", 64'(cap.a_source), 64'(Src));
        check("rd_rdata", 64'(h_rdata_o), 32'hDEADBEEF);

        addr_phase(NseqT, 32'h1003, 1'b1, 3'd0);
        data_phase(32'hAB000000, 4'h8, 0, 1'b0, 32'h55555555);
        check("pw_opcode", 64'(cap.a_opcode), 64'(PutPartialData));
        check("pw_mask", 64'(cap.a_mask), 4'h8);
        check("pw_size", 64'(cap.a_size), 0);
        check("pw_data", 64'(cap.a_data), 32'hAB000000);
        check("pw_resp", 64'(fin_resp), 0);
        check("pw_rdata_hold", 64'(h_rdata_o), 32'hDEADBEEF);

        addr_phase(NseqT, 32'h3000, 1'b1, 3'd2);
        data_phase(32'h12345678, 4'hF, 5, 1'b0, 32'h0);
        check("fw_opcode", 64'(cap.a_opcode), 64'(PutFullData));
        check("fw_mask", 64'(cap.a_mask), 4'hF);
        check("fw_data", 64'(cap.a_data), 32'h12345678);
        check("fw_stable", 64'(unstable), 0);
        check("fw_waits", 64'(waits), 7);

        addr_phase(NseqT, 32'h4000, 1'b0, 3'd2);
        data_phase(32'h0, 4'h0, 0, 1'b1, 32'h0BADF00D);
        check("derr_waits", 64'(waits), 3);
        check("derr_err1_resp", 64'(last_wait_resp), 1);
        check("derr_err2_resp", 64'(fin_resp), 1);

        addr_phase(NseqT, 32'h4100, 1'b0, 3'd3);
        data_phase(32'h0, 4'h0, 0, 1'b0, 32'h0);
        check("size_no_avalid", 64'(any_avalid), 0);
        check("size_waits", 64'(waits), 1);
        check("size_err1_resp", 64'(last_wait_resp), 1);
        check("size_err2_resp", 64'(fin_resp), 1);

        nreq = 0;
        addr_phase(NseqT, 32'h2000, 1'b0, 3'd2);
        data_phase(32'h0, 4'h0, 0, 1'b0, 32'h11111111);
        check("b2b_first_addr", 64'(cap.a_address), 32'h2000);
        check("b2b_first_rdata", 64'(h_rdata_o), 32'h11111111);
        addr_phase(SeqT, 32'h2004, 1'b0, 3'd2);
        data_phase(32'h0, 4'h0, 0, 1'b0, 32'h22222222);
        check("b2b_nreq", 64'(nreq), 2);
        check("b2b_second_addr", 64'(cap.a_address), 32'h2004);
        check("b2b_second_op", 64'(cap.a_opcode), 64'(Get));
        check("b2b_second_src", 64'(cap.a_source), 64'(Src));
        check("b2b_second_rdata", 64'(h_rdata_o), 32'h22222222);
        check("b2b_resp", 64'(fin_resp), 0);

        addr_phase(IdleT, 32'h6000, 1'b0, 3'd2);
        @(posedge clk_i); #1;
        check("idle_readyout", 64'(h_readyout_o), 1);
        check("idle_resp", 64'(h_resp_o), 0);
        check("idle_avalid", 64'(tl_o.a_valid), 0);
        addr_phase(BusyT, 32'h6004, 1'b0, 3'd2);
        @(posedge clk_i); #1;
        check("busy_readyout", 64'(h_readyout_o), 1);
        check("busy_avalid", 64'(tl_o.a_valid), 0);
        @(posedge clk_i); #1;
        check("busy_avalid_2", 64'(tl_o.a_valid), 0);

        addr_phase(NseqT, 32'h5000, 1'b0, 3'd2);
        @(posedge clk_i); #1;
        h_sel_i = 1'b0; h_trans_i = IdleT;
        tl_i.a_ready = 1'b1;
        @(posedge clk_i); #1;
        tl_i.a_ready = 1'b0;
        check("rstmid_dready", 64'(tl_o.d_ready), 1);
        rst_ni = 1'b0;
        #1;
        check("rstmid_readyout", 64'(h_readyout_o), 1);
        check("rstmid_resp", 64'(h_resp_o), 0);
        check("rstmid_rdata", 64'(h_rdata_o), 0);
        check("rstmid_tl_o", 64'(|tl_o), 0);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("post_rst_readyout", 64'(h_readyout_o), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
